// File: rtl/btn_debouncer.sv
// Per-button debouncer producing debounced level, single-shot, auto-repeat and continuous enables.
// Optional `BTN_SYNC_EN inserts a 2-flop synchronizer on every PB bit (adds 2 cycles of latency).
module btn_debouncer_lane #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int CW           = 27
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pb,
  output logic o_dpb,
  output logic o_scen,
  output logic o_mcen,
  output logic o_ccen
);
  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    HOLD    = 3'd3,
    RPT     = 3'd4,
    WFCR    = 3'd5
  } state_t;

  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HLD_MAX = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RPT_MAX = CW'(REPEAT_CYC - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_rpt_pulse, w_rpt_pulse_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= INI;
      r_cnt       <= '0;
      r_rpt_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rpt_pulse <= w_rpt_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rpt_pulse_nxt = 1'b0;
    case (r_state)
      INI: begin
        w_cnt_nxt = '0;
        if (i_pb) w_state_nxt = WQ;
      end
      WQ: begin
        if (!i_pb) begin
          w_state_nxt = INI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_MAX) begin
          w_state_nxt = SCEN_ST;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      SCEN_ST: begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = '0;
      end
      HOLD: begin
        if (!i_pb) begin
          w_state_nxt = WFCR;
          w_cnt_nxt   = '0;
        end else if (r_cnt == HLD_MAX) begin
          w_state_nxt = RPT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RPT: begin
        // Repeat pulse is registered so the first one lands REPEAT_CYC cycles into RPT
        if (!i_pb) begin
          w_state_nxt = WFCR;
          w_cnt_nxt   = '0;
        end else if (r_cnt == RPT_MAX) begin
          w_cnt_nxt       = '0;
          w_rpt_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      WFCR: begin
        if (i_pb) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_MAX) begin
          w_state_nxt = INI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = INI;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_dpb  = (r_state == SCEN_ST) || (r_state == HOLD) ||
                  (r_state == RPT)     || (r_state == WFCR);
  assign o_scen = (r_state == SCEN_ST);
  assign o_mcen = (r_state == SCEN_ST) || r_rpt_pulse;
  assign o_ccen = (r_state == RPT);
endmodule

module btn_debouncer #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] PB,
  output logic [N_BTN-1:0] DPB,
  output logic [N_BTN-1:0] SCEN,
  output logic [N_BTN-1:0] MCEN,
  output logic [N_BTN-1:0] CCEN
);
  localparam int MAX_DH = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_C  = (MAX_DH > REPEAT_CYC) ? MAX_DH : REPEAT_CYC;
  localparam int CW     = $clog2(MAX_C) + 1;

  logic [N_BTN-1:0] w_pb;

`ifdef BTN_SYNC_EN
  logic [N_BTN-1:0] r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= PB;
      r_sync2 <= r_sync1;
    end
  end
  assign w_pb = r_sync2;
`else
  assign w_pb = PB;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_debouncer_lane #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .CW           (CW)
    ) u_lane (
      .i_clk   (clk),
      .i_reset (reset),
      .i_pb    (w_pb[i]),
      .o_dpb   (DPB[i]),
      .o_scen  (SCEN[i]),
      .o_mcen  (MCEN[i]),
      .o_ccen  (CCEN[i])
    );
  end
endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE_CYC=4, HOLD_CYC=8, REPEAT_CYC=3.
// Expected outputs are queued as each step is driven and checked after the clock edge.
module tb_btn_debouncer;
  typedef struct packed {
    logic [3:0] dpb;
    logic [3:0] scen;
    logic [3:0] mcen;
    logic [3:0] ccen;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] PB;
  logic [3:0] DPB, SCEN, MCEN, CCEN;

  out_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  btn_debouncer #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .HOLD_CYC(8), .REPEAT_CYC(3)
  ) dut (
    .clk(clk), .reset(reset), .PB(PB),
    .DPB(DPB), .SCEN(SCEN), .MCEN(MCEN), .CCEN(CCEN)
  );

  always #5 clk = ~clk;

  // {dpb,scen,mcen,ccen} of a held button in cycle c (cycle 1 follows the first PB=1 edge)
  function automatic logic [3:0] held(input int c);
    if (c <= 4) return 4'b0000;
    if (c == 5) return 4'b1110;
    if (c < 14) return 4'b1000;
    if (c >= 17 && ((c - 17) % 3) == 0) return 4'b1011;
    return 4'b1001;
  endfunction

  function automatic out_t mk(input int c0, input int c1, input int c2, input int c3);
    int         cs[4];
    logic [3:0] h;
    out_t       o;
    cs = '{c0, c1, c2, c3};
    o  = '0;
    for (int b = 0; b < 4; b++) begin
      h         = held(cs[b]);
      o.dpb[b]  = h[3];
      o.scen[b] = h[2];
      o.mcen[b] = h[1];
      o.ccen[b] = h[0];
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] pb, input out_t e);
    out_t got, exp;
    reset = rst;
    PB    = pb;
    q.push_back(e);
    @(posedge clk);
    #1;
    exp = q.pop_front();
    got = {DPB, SCEN, MCEN, CCEN};
    chk("DPB",  got.dpb,  exp.dpb);
    chk("SCEN", got.scen, exp.scen);
    chk("MCEN", got.mcen, exp.mcen);
    chk("CCEN", got.ccen, exp.ccen);
  endtask

  initial begin
    out_t       z, e;
    logic [7:0] bounce;
    z      = '0;
    reset  = 1'b1;
    PB     = '0;
    bounce = 8'b0000_0010;  // bit i is the PB[2] sample in release step i

    // reset state
    step(1'b1, 4'b0000, z);
    step(1'b1, 4'b0000, z);

    // single press on bit 0
    for (int c = 1; c <= 8; c++) step(1'b0, 4'b0001, mk(c, 0, 0, 0));
    step(1'b1, 4'b0001, z);
    step(1'b0, 4'b0000, z);

    // short glitch on bit 1
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, z);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, z);

    // long hold on bit 2 into auto-repeat
    for (int c = 1; c <= 30; c++) step(1'b0, 4'b0100, mk(0, 0, c, 0));

    // bouncy release of bit 2: DPB holds until 4 quiet samples follow the last 1
    for (int i = 0; i < 8; i++) begin
      e        = z;
      e.dpb[2] = (i < 5);
      step(1'b0, bounce[i] ? 4'b0100 : 4'b0000, e);
    end

    // simultaneous press of bits 0 and 3
    step(1'b1, 4'b0000, z);
    for (int c = 1; c <= 16; c++) step(1'b0, 4'b1001, mk(c, 0, 0, c));

    // reset while held in auto-repeat, then full re-debounce
    step(1'b1, 4'b1001, z);
    for (int c = 1; c <= 8; c++) step(1'b0, 4'b1001, mk(c, 0, 0, c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
